// File: rtl/pll_reset_sequencer.sv
// -----------------------------------------------------------------------------
// pll_reset_sequencer
//
// Brings up the Gowin PLL and the reset of the logic clocked from its outputs.
// The block pulses the PLL reset and waits for lock, retrying on a timeout.
// Lock must then stay stable for a while before a hold-off reset is released
// to the USB/video logic. It runs on the PLL reference clock (the same net as
// the PLL clkin), so it keeps counting while the PLL is unlocked.
//
// Sequence:  PLL_RST -> WAIT_LOCK -> STABLE -> HOLD -> RUN
//   - WAIT_LOCK timeout, loss of lock in HOLD, or loss of lock in RUN all
//     re-pulse the PLL and bump retry_count.
//   - A lock glitch during STABLE only restarts the wait. The PLL has not been
//     trusted yet, so the block does not re-pulse it.
//
// Parameters:
//   POR_CYCLES   - width of each PLL reset pulse, in clk cycles (>= 1)
//   LOCK_TIMEOUT - cycles to wait for lock after a PLL reset pulse (>= 1)
//   LOCK_STABLE  - consecutive synchronised-lock cycles before the hold-off
//   RST_HOLD     - cycles sys_rst stays asserted after lock is qualified
//
// Ports:
//   clk         in   reference clock (PLL clkin)
//   reset       in   synchronous, active-high
//   pll_lock    in   PLL lock, asynchronous to clk
//   pll_reset   out  PLL reset, active-high
//   sys_rst     out  reset for the PLL-clocked logic, active-high
//   ready       out  high only in RUN
//   lock_lost   out  one-cycle pulse, aligned with the first PLL_RST cycle
//                    after lock drops in RUN
//   retry_count out  saturating (at 15) count of PLL re-resets
// -----------------------------------------------------------------------------
module pll_reset_sequencer #(
    parameter int POR_CYCLES   = 16,
    parameter int LOCK_TIMEOUT = 48000,
    parameter int LOCK_STABLE  = 1024,
    parameter int RST_HOLD     = 256
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pll_lock,
    output logic       pll_reset,
    output logic       sys_rst,
    output logic       ready,
    output logic       lock_lost,
    output logic [3:0] retry_count
);

    // One shared counter serves every state, so it is sized for the longest
    // interval. The extra bit keeps the terminal compares free of wrap-around.
    localparam int MAX_AB    = (POR_CYCLES  > LOCK_TIMEOUT) ? POR_CYCLES  : LOCK_TIMEOUT;
    localparam int MAX_CD    = (LOCK_STABLE > RST_HOLD)     ? LOCK_STABLE : RST_HOLD;
    localparam int MAX_PARAM = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CNT_W     = $clog2(MAX_PARAM) + 1;

    localparam logic [CNT_W-1:0] POR_LAST     = CNT_W'(POR_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(RST_HOLD - 1);

    localparam logic [3:0] RETRY_MAX = 4'd15;

    typedef enum logic [2:0] {
        PLL_RST,
        WAIT_LOCK,
        STABLE,
        HOLD,
        RUN
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic             lock_meta;
    logic             lock_s;
    logic             retry_inc;
    logic             lost_next;

    // -------------------------------------------------------------------------
    // Lock synchroniser. pll_lock is produced by the PLL's own analog loop and
    // has no timing relationship to clk. It reaches the FSM only via lock_s.
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only. Every flop
    // then samples the values from before the edge, so lock_meta -> lock_s
    // forms a true two-stage chain and not a single wire.
    always_ff @(posedge clk) begin
        if (reset) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= pll_lock;
            lock_s    <= lock_meta;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic.
    // -------------------------------------------------------------------------
    // NOTE: every signal assigned here gets a default first. A branch that
    // forgets to assign one then falls back to the default and does not infer
    // a latch.
    always_comb begin
        state_next = state;
        retry_inc  = 1'b0;
        lost_next  = 1'b0;

        unique case (state)
            PLL_RST: begin
                if (cnt == POR_LAST) begin
                    state_next = WAIT_LOCK;
                end
            end

            WAIT_LOCK: begin
                // Lock is checked first, so a lock that arrives on the last
                // timeout cycle still counts and no retry is spent.
                if (lock_s) begin
                    state_next = STABLE;
                end else if (cnt == TIMEOUT_LAST) begin
                    state_next = PLL_RST;
                    retry_inc  = 1'b1;
                end
            end

            STABLE: begin
                // A dropout here means lock was not yet stable. Go back to
                // waiting and do not reset the PLL again.
                if (!lock_s) begin
                    state_next = WAIT_LOCK;
                end else if (cnt == STABLE_LAST) begin
                    state_next = HOLD;
                end
            end

            HOLD: begin
                if (!lock_s) begin
                    state_next = PLL_RST;
                    retry_inc  = 1'b1;
                end else if (cnt == HOLD_LAST) begin
                    state_next = RUN;
                end
            end

            RUN: begin
                if (!lock_s) begin
                    state_next = PLL_RST;
                    retry_inc  = 1'b1;
                    lost_next  = 1'b1;
                end
            end

            default: begin
                state_next = PLL_RST;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State, counter, retry counter and lock_lost pulse.
    // -------------------------------------------------------------------------
    // NOTE: reset is synchronous, so it is tested inside the clocked block and
    // has no entry in the sensitivity list.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= PLL_RST;
            cnt         <= '0;
            retry_count <= '0;
            lock_lost   <= 1'b0;
        end else begin
            state     <= state_next;
            lock_lost <= lost_next;

            // The counter restarts on every state change. In RUN no timed exit
            // exists, so the counter holds to avoid pointless toggling.
            if (state_next != state) begin
                cnt <= '0;
            end else if (state != RUN) begin
                cnt <= cnt + 1'b1;
            end

            if (retry_inc && (retry_count != RETRY_MAX)) begin
                retry_count <= retry_count + 4'd1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Moore outputs, decoded only from the registered state. This leaves no
    // combinational path from pll_lock to any output.
    // -------------------------------------------------------------------------
    always_comb begin
        pll_reset = (state == PLL_RST);
        sys_rst   = (state != RUN);
        ready     = (state == RUN);
    end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pll_reset_sequencer
//
// Directed bench for pll_reset_sequencer, built with small parameters:
// POR_CYCLES=4, LOCK_TIMEOUT=20, LOCK_STABLE=8, RST_HOLD=6.
//
// Timing convention: inputs change and outputs are sampled 1 time unit after
// each rising clk edge. "Tick n" means the n-th edge after the stimulus point
// that the comment names.
// -----------------------------------------------------------------------------
module tb_pll_reset_sequencer;

    localparam int POR_CYCLES   = 4;
    localparam int LOCK_TIMEOUT = 20;
    localparam int LOCK_STABLE  = 8;
    localparam int RST_HOLD     = 6;
    localparam int PERIOD       = POR_CYCLES + LOCK_TIMEOUT;   // 24

    logic       clk;
    logic       reset;
    logic       pll_lock;
    logic       pll_reset;
    logic       sys_rst;
    logic       ready;
    logic       lock_lost;
    logic [3:0] retry_count;

    int total;
    int bad;

    pll_reset_sequencer #(
        .POR_CYCLES  (POR_CYCLES),
        .LOCK_TIMEOUT(LOCK_TIMEOUT),
        .LOCK_STABLE (LOCK_STABLE),
        .RST_HOLD    (RST_HOLD)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pll_lock   (pll_lock),
        .pll_reset  (pll_reset),
        .sys_rst    (sys_rst),
        .ready      (ready),
        .lock_lost  (lock_lost),
        .retry_count(retry_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold reset for two edges, check the reset values, then release reset.
    // On return the DUT is in PLL_RST with cnt=0: cycle 0 after release.
    task automatic do_reset();
        reset    = 1'b1;
        pll_lock = 1'b0;
        tick();
        tick();
        check("rst_pll_reset", pll_reset, 1);
        check("rst_sys_rst", sys_rst, 1);
        check("rst_ready", ready, 0);
        check("rst_lock_lost", lock_lost, 0);
        check("rst_retry", retry_count, 0);
        reset = 1'b0;
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        reset    = 1'b1;
        pll_lock = 1'b0;

        // ---------------- 1. normal bring-up ----------------
        do_reset();
        check("s1_por_c0", pll_reset, 1);
        for (int i = 1; i < POR_CYCLES; i++) begin
            tick();
            check("s1_por_high", pll_reset, 1);
        end
        tick();                                   // cycle 4: WAIT_LOCK
        check("s1_por_low", pll_reset, 0);
        repeat (6) tick();                        // cycle 10
        pll_lock = 1'b1;
        for (int n = 0; n < 16; n++) begin        // edges t .. t+15
            tick();
            check("s1_not_ready", ready, 0);
            check("s1_sys_rst_hi", sys_rst, 1);
        end
        tick();                                   // edge t+16
        check("s1_ready", ready, 1);
        check("s1_sys_rst_lo", sys_rst, 0);
        check("s1_pll_reset", pll_reset, 0);
        check("s1_retry", retry_count, 0);

        // ---------------- 2. no lock, retry saturation ----------------
        do_reset();
        for (int c = 1; c <= 16 * PERIOD; c++) begin
            tick();
            check("s2_pll_reset", pll_reset, ((c % PERIOD) < POR_CYCLES) ? 1 : 0);
            check("s2_retry", retry_count, ((c / PERIOD) > 15) ? 15 : (c / PERIOD));
            check("s2_sys_rst", sys_rst, 1);
        end

        // ---------------- 3. one-cycle glitch during STABLE ----------------
        do_reset();
        repeat (4) tick();                        // cycle 4: WAIT_LOCK cnt=0
        check("s3_wait", pll_reset, 0);
        pll_lock = 1'b1;
        repeat (6) tick();                        // edges t .. t+5
        pll_lock = 1'b0;                          // sampled at t+6 only
        tick();                                   // edge t+6
        pll_lock = 1'b1;                          // re-sampled at t+7
        // lock_s is 0 during STABLE cnt=5. WAIT_LOCK after t+8, STABLE after
        // t+9, RUN after t+7+16 = t+23.
        for (int n = 7; n <= 22; n++) begin
            tick();
            check("s3_not_ready", ready, 0);
            check("s3_no_pulse", pll_reset, 0);
            check("s3_retry", retry_count, 0);
        end
        tick();                                   // edge t+23
        check("s3_ready", ready, 1);
        check("s3_sys_rst_lo", sys_rst, 0);
        check("s3_retry_end", retry_count, 0);

        // ---------------- 4. lock loss in RUN ----------------
        pll_lock = 1'b0;
        tick();                                   // edge e
        check("s4_e0_ready", ready, 1);
        check("s4_e0_lost", lock_lost, 0);
        tick();                                   // edge e+1
        check("s4_e1_ready", ready, 1);
        check("s4_e1_lost", lock_lost, 0);
        tick();                                   // edge e+2
        check("s4_lost_pulse", lock_lost, 1);
        check("s4_ready_lo", ready, 0);
        check("s4_sys_rst_hi", sys_rst, 1);
        check("s4_pll_reset_hi", pll_reset, 1);
        check("s4_retry", retry_count, 1);
        for (int n = 3; n <= 5; n++) begin        // edges e+3 .. e+5
            tick();
            check("s4_lost_clear", lock_lost, 0);
            check("s4_pulse_hold", pll_reset, 1);
        end
        tick();                                   // edge e+6: WAIT_LOCK
        check("s4_pulse_end", pll_reset, 0);
        pll_lock = 1'b1;
        for (int n = 0; n < 16; n++) begin
            tick();
            check("s4_relock_wait", ready, 0);
        end
        tick();
        check("s4_relock_ready", ready, 1);
        check("s4_retry_end", retry_count, 1);

        // ---------------- 5. timeout / lock collision ----------------
        do_reset();
        repeat (21) tick();                       // cycle 21: WAIT_LOCK cnt=17
        pll_lock = 1'b1;                          // lock_s=1 at WAIT cnt=19
        repeat (3) tick();                        // tick 24: STABLE
        check("s5_no_pulse", pll_reset, 0);
        check("s5_retry", retry_count, 0);
        for (int n = 25; n <= 37; n++) begin
            tick();
            check("s5_not_ready", ready, 0);
            check("s5_no_pulse_q", pll_reset, 0);
        end
        tick();                                   // tick 38 = t+16
        check("s5_ready", ready, 1);
        check("s5_retry_end", retry_count, 0);

        // ---------------- 6. reset mid-HOLD with retry_count=3 ----------------
        do_reset();
        repeat (3 * PERIOD) tick();               // cycle 72: third re-pulse
        check("s6_retry3", retry_count, 3);
        check("s6_pulse", pll_reset, 1);
        repeat (4) tick();                        // cycle 76: WAIT_LOCK
        check("s6_wait", pll_reset, 0);
        pll_lock = 1'b1;
        repeat (13) tick();                       // tick 89: HOLD cnt=2
        check("s6_hold_sys_rst", sys_rst, 1);
        check("s6_hold_ready", ready, 0);
        check("s6_hold_retry", retry_count, 3);
        reset = 1'b1;
        tick();
        check("s6_rst_pll_reset", pll_reset, 1);
        check("s6_rst_sys_rst", sys_rst, 1);
        check("s6_rst_retry", retry_count, 0);
        check("s6_rst_ready", ready, 0);
        reset = 1'b0;                             // cycle 0 after release
        check("s6_por_c0", pll_reset, 1);
        for (int i = 1; i < POR_CYCLES; i++) begin
            tick();
            check("s6_por_high", pll_reset, 1);
        end
        tick();                                   // cycle 4
        check("s6_por_low", pll_reset, 0);
        check("s6_retry_end", retry_count, 0);
        // Lock is already synchronised on entry to WAIT_LOCK. STABLE follows
        // after tick 5, HOLD after tick 13 and RUN after tick 19.
        repeat (14) tick();                       // tick 18
        check("s6_pre_ready", ready, 0);
        tick();                                   // tick 19
        check("s6_ready", ready, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
